// File: rtl/jpc_ifetch_pq_pkg.sv
// Shared types for the instruction-fetch prefetch queue: redirect
// selection enum and the priority function that picks one source.
`ifndef JPC_CONFIG_V
`include "jpc_config.sv"
`endif
package jpc_ifetch_pq_pkg;

    localparam int INSTR_W     = `JPC_INSTRUCTION_WIDTH;
    localparam int INSTR_BYTES = `JPC_INSTR_BYTES;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_FLUSH,
        RD_BRANCH,
        RD_TRAP
    } redir_e;

    // trap beats branch beats flush
    function automatic redir_e redir_sel(
        input logic trap,
        input logic branch,
        input logic flush
    );
        redir_e r;
        if (trap) begin
            r = RD_TRAP;
        end else if (branch) begin
            r = RD_BRANCH;
        end else if (flush) begin
            r = RD_FLUSH;
        end else begin
            r = RD_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/jpc_config.sv
// Shared JPC core configuration: address/instruction widths and the
// byte stride between consecutive instructions.
`ifndef JPC_CONFIG_V
`define JPC_CONFIG_V
`define JPC_ADDRESS_WIDTH 32
`define JPC_INSTRUCTION_WIDTH 32
`define JPC_INSTR_BYTES 4
`endif

// File: rtl/jpc_ifq.sv
// Circular prefetch queue of {PC, instruction} pairs with push, pop
// and a clear that dominates both.
`ifndef JPC_CONFIG_V
`include "jpc_config.sv"
`endif
module jpc_ifq
    import jpc_ifetch_pq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int DATA_W = INSTR_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [PC_W-1:0]   push_pc_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [PC_W-1:0]   head_pc_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    // pointer and occupancy next state; clear discards everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // entry storage, zeroed so an empty queue presents zero outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (do_push && !clear_i) begin
            pc_q[wr_ptr_q]   <= push_pc_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_pc_o   = pc_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/jpc_ifetch_pq.sv
// Instruction fetch unit: issues BRAM reads, queues returns, redirects.
// Optional macro JPC_IFETCH_ALIGN_CHECK_EN: misaligned redirect faults.
`ifndef JPC_CONFIG_V
`include "jpc_config.sv"
`endif
module jpc_ifetch_pq
    import jpc_ifetch_pq_pkg::*;
#(
    parameter int                ADDR_W   = `JPC_ADDRESS_WIDTH,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_I,
    input  logic               flush_I,
    input  logic               branch_taken_I,
    input  logic [ADDR_W-1:0]  branch_addr_I,
    input  logic               trap_taken_I,
    input  logic [ADDR_W-1:0]  trap_address_I,
    output logic               mem_req_O,
    output logic [ADDR_W-1:0]  mem_addr_O,
    input  logic [INSTR_W-1:0] mem_data_I,
    output logic               instr_valid_O,
    input  logic               instr_ready_I,
    output logic [INSTR_W-1:0] instr_O,
    output logic [ADDR_W-1:0]  instr_pc_O,
    output logic               fault_O
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]    LIMIT = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              inflight_q, inflight_d;
    logic              halted;
    redir_e            redir;
    logic              redir_any, issue, push, pop;
    logic [CNT_W-1:0]  count, discard;
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] target_raw, target, rewind_pc;

    assign redir     = redir_sel(trap_taken_I, branch_taken_I, flush_I);
    assign redir_any = (redir != RD_NONE);
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight_q);
    assign issue     = rst && !stall_I && !halted && !redir_any
                       && (occupancy < LIMIT);
    assign pop       = instr_valid_O && instr_ready_I;
    assign push      = inflight_q && !redir_any;

    // Queue entries and the in-flight fetch are always consecutive PCs
    // ending just below fetch_pc, so the oldest discarded PC is found by
    // stepping back over everything that will be dropped.
    assign discard   = count - CNT_W'(pop) + CNT_W'(inflight_q);
    assign rewind_pc = fetch_pc_q - ADDR_W'(discard) * STEP;

    assign target_raw = (redir == RD_TRAP) ? trap_address_I : branch_addr_I;

`ifdef JPC_IFETCH_ALIGN_CHECK_EN
    logic halted_q, halted_d;
    logic fault_q, fault_d;

    assign target = target_raw;

    // misaligned target halts; only an aligned trap recovers
    always_comb begin
        halted_d = halted_q;
        fault_d  = fault_q;
        if (redir == RD_TRAP || redir == RD_BRANCH) begin
            if (target_raw[1:0] != 2'b00) begin
                halted_d = 1'b1;
                fault_d  = 1'b1;
            end else if (redir == RD_TRAP) begin
                halted_d = 1'b0;
                fault_d  = 1'b0;
            end
        end
    end

    // fault and halt flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign halted  = halted_q;
    assign fault_O = fault_q;
`else
    assign target  = target_raw & ~ADDR_W'(3);
    assign halted  = 1'b0;
    assign fault_O = 1'b0;
`endif

    // fetch pointer: redirect load, flush rewind, or sequential advance
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        infl_pc_d  = infl_pc_q;
        inflight_d = 1'b0;
        unique case (redir)
            RD_TRAP, RD_BRANCH: fetch_pc_d = target;
            RD_FLUSH:           fetch_pc_d = rewind_pc;
            default: begin
                if (issue) begin
                    fetch_pc_d = fetch_pc_q + STEP;
                    infl_pc_d  = fetch_pc_q;
                    inflight_d = 1'b1;
                end
            end
        endcase
    end

    // fetch pointer and in-flight request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            infl_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_pc_q  <= infl_pc_d;
            inflight_q <= inflight_d;
        end
    end

    jpc_ifq #(
        .DEPTH  (DEPTH),
        .PC_W   (ADDR_W),
        .DATA_W (INSTR_W),
        .CNT_W  (CNT_W)
    ) u_ifq (
        .clk_i       (clk),
        .rst_ni      (rst),
        .clear_i     (redir_any),
        .push_i      (push),
        .push_pc_i   (infl_pc_q),
        .push_data_i (mem_data_I),
        .pop_i       (pop),
        .head_pc_o   (instr_pc_O),
        .head_data_o (instr_O),
        .count_o     (count)
    );

    assign mem_req_O     = issue;
    assign mem_addr_O    = fetch_pc_q;
    assign instr_valid_O = (count != '0);

endmodule

// File: tb/tb_jpc_ifetch_pq.sv
// Directed bench for jpc_ifetch_pq with DEPTH=4 and 32-bit addresses.
// The BRAM model returns addr ^ 0xC0DE0000 one cycle after the request.
`timescale 1ns/1ps
module tb_jpc_ifetch_pq;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall, flush, br, trap, ready;
    logic [AW-1:0] br_addr, trap_addr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          valid;
    logic [31:0]   instr;
    logic [AW-1:0] ipc;
    logic          fault;

    int total = 0;
    int bad   = 0;

    jpc_ifetch_pq #(
        .ADDR_W   (AW),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_I        (stall),
        .flush_I        (flush),
        .branch_taken_I (br),
        .branch_addr_I  (br_addr),
        .trap_taken_I   (trap),
        .trap_address_I (trap_addr),
        .mem_req_O      (mem_req),
        .mem_addr_O     (mem_addr),
        .mem_data_I     (mem_data),
        .instr_valid_O  (valid),
        .instr_ready_I  (ready),
        .instr_O        (instr),
        .instr_pc_O     (ipc),
        .fault_O        (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) mem_data <= rom(mem_addr);

    task automatic idle();
        stall = 1'b0; flush = 1'b0; br = 1'b0; trap = 1'b0;
        ready = 1'b0; br_addr = '0; trap_addr = '0;
    endtask

    // returns #1 after the deassertion negedge, before the next posedge
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic wait_head(input logic [31:0] pc, output bit found);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid === 1'b1 && ipc === pc) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // k=0 is the current negedge
    task automatic first_valid(output int seen, output logic [31:0] pc);
        seen = -1;
        pc = '0;
        for (int k = 0; k < 8; k++) begin
            if (valid === 1'b1) begin
                seen = k;
                pc = ipc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        idle();
        ready = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", valid);
        end
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL reset_req got=%b exp=0", mem_req);
        end
        total++;
        if (fault !== 1'b0) begin
            bad++; $display("FAIL reset_fault got=%b exp=0", fault);
        end
        total++;
        if (instr !== 32'h0 || ipc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outs got=%h/%h exp=0/0", instr, ipc);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        apply_reset();
        ready = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL first_req got=%b@%h exp=1@0", mem_req, mem_addr);
        end
        @(negedge clk);
        total++;
        if (valid !== 1'b0) begin
            bad++; $display("FAIL stream_lat got=%b exp=0", valid);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = 32'(i * 4);
            total++;
            if (valid !== 1'b1 || ipc !== e || instr !== rom(e)) begin
                bad++;
                $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h",
                         i, valid, ipc, instr, e, rom(e));
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        apply_reset();
        repeat (10) @(negedge clk);
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL full_no_req got=%b exp=0", mem_req);
        end
        total++;
        if (valid !== 1'b1 || ipc !== 32'h0) begin
            bad++;
            $display("FAIL full_head got=%b/%h exp=1/0", valid, ipc);
        end
        stall = 1'b1;
        ready = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (valid === 1'b1) begin
                total++;
                if (ipc !== 32'(n * 4)) begin
                    bad++;
                    $display("FAIL drain_%0d got=%h exp=%h", n, ipc, n * 4);
                end
                n++;
            end
            @(negedge clk);
        end
        total++;
        if (n != 4) begin
            bad++; $display("FAIL held_entries got=%0d exp=4", n);
        end
        stall = 1'b0;
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc [4];
        bit          exp_v  [4];
        exp_v  = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_pc = '{32'h0, 32'h0, 32'h40, 32'h44};
        apply_reset();
        repeat (4) @(negedge clk);
        total++;
        if (valid !== 1'b1 || ipc !== 32'h0) begin
            bad++;
            $display("FAIL br_pre_head got=%b/%h exp=1/0", valid, ipc);
        end
        br = 1'b1;
        br_addr = 32'h40;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL br_req_block got=%b exp=0", mem_req);
        end
        @(negedge clk);
        br = 1'b0;
        ready = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            bad++;
            $display("FAIL br_refetch got=%b@%h exp=1@40", mem_req, mem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (valid !== exp_v[k] || (exp_v[k] && ipc !== exp_pc[k])) begin
                bad++;
                $display("FAIL br_seq_%0d got=%b/%h exp=%b/%h",
                         k, valid, ipc, exp_v[k], exp_pc[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_priority();
        int          seen;
        logic [31:0] pc;
        apply_reset();
        ready = 1'b1;
        repeat (4) @(negedge clk);
        trap = 1'b1; trap_addr = 32'h80;
        br   = 1'b1; br_addr   = 32'h40;
        @(negedge clk);
        trap = 1'b0;
        br = 1'b0;
        first_valid(seen, pc);
        total++;
        if (seen != 2 || pc !== 32'h80) begin
            bad++;
            $display("FAIL trap_prio got=%0d/%h exp=2/80", seen, pc);
        end
    endtask

    task automatic test_flush();
        bit          found;
        int          seen;
        logic [31:0] pc;
        apply_reset();
        ready = 1'b1;
        wait_head(32'h24, found);
        total++;
        if (!found) begin
            bad++; $display("FAIL flush_reach got=timeout exp=head 24");
        end
        ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        ready = 1'b1;
        #1;
        total++;
        if (valid !== 1'b0) begin
            bad++; $display("FAIL flush_empty got=%b exp=0", valid);
        end
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h24) begin
            bad++;
            $display("FAIL flush_rewind got=%b@%h exp=1@24", mem_req, mem_addr);
        end
        first_valid(seen, pc);
        total++;
        if (seen != 2 || pc !== 32'h24) begin
            bad++;
            $display("FAIL flush_refetch got=%0d/%h exp=2/24", seen, pc);
        end
    endtask

    task automatic test_stall();
        bit          found;
        int          seen;
        logic [31:0] pc;
        apply_reset();
        ready = 1'b1;
        wait_head(32'h8, found);
        total++;
        if (!found) begin
            bad++; $display("FAIL stall_reach got=timeout exp=head 8");
        end
        stall = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL stall_req_0 got=%b exp=0", mem_req);
        end
        @(negedge clk);
        total++;
        if (valid !== 1'b1 || ipc !== 32'hC) begin
            bad++;
            $display("FAIL stall_inflight got=%b/%h exp=1/c", valid, ipc);
        end
        for (int k = 1; k <= 5; k++) begin
            total++;
            if (mem_req !== 1'b0 || mem_addr !== 32'h10) begin
                bad++;
                $display("FAIL stall_frozen_%0d got=%b@%h exp=0@10",
                         k, mem_req, mem_addr);
            end
            if (k < 5) @(negedge clk);
        end
        stall = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            bad++;
            $display("FAIL stall_resume got=%b@%h exp=1@10", mem_req, mem_addr);
        end
        first_valid(seen, pc);
        total++;
        if (seen != 2 || pc !== 32'h10) begin
            bad++;
            $display("FAIL stall_next got=%0d/%h exp=2/10", seen, pc);
        end
    endtask

    task automatic test_wrap();
        int          seen;
        logic [31:0] pc;
        logic [31:0] exp_pc [3];
        exp_pc = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        apply_reset();
        ready = 1'b1;
        trap = 1'b1;
        trap_addr = 32'hFFFF_FFF8;
        @(negedge clk);
        trap = 1'b0;
        first_valid(seen, pc);
        total++;
        if (seen != 2 || pc !== 32'hFFFF_FFF8) begin
            bad++;
            $display("FAIL wrap_first got=%0d/%h exp=2/fffffff8", seen, pc);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (valid !== 1'b1 || ipc !== exp_pc[k]) begin
                bad++;
                $display("FAIL wrap_%0d got=%b/%h exp=1/%h",
                         k, valid, ipc, exp_pc[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int          seen;
        logic [31:0] pc;
        apply_reset();
        ready = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (valid !== 1'b1) begin
            bad++; $display("FAIL mid_pre got=%b exp=1", valid);
        end
        rst = 1'b0;
        #1;
        total++;
        if (valid !== 1'b0 || mem_req !== 1'b0 || ipc !== 32'h0) begin
            bad++;
            $display("FAIL mid_rst got=%b/%b/%h exp=0/0/0", valid, mem_req, ipc);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL mid_first_req got=%b@%h exp=1@0", mem_req, mem_addr);
        end
        first_valid(seen, pc);
        total++;
        if (seen != 2 || pc !== 32'h0) begin
            bad++;
            $display("FAIL mid_first_valid got=%0d/%h exp=2/0", seen, pc);
        end
    endtask

    task automatic test_align();
        int          seen;
        logic [31:0] pc;
        apply_reset();
        ready = 1'b1;
        br = 1'b1;
        br_addr = 32'h42;
        @(negedge clk);
        br = 1'b0;
        #1;
`ifdef JPC_IFETCH_ALIGN_CHECK_EN
        total++;
        if (fault !== 1'b1) begin
            bad++; $display("FAIL align_fault got=%b exp=1", fault);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem_req !== 1'b0 || valid !== 1'b0) begin
                bad++;
                $display("FAIL align_halt_%0d got=%b/%b exp=0/0",
                         k, mem_req, valid);
            end
            @(negedge clk);
        end
        trap = 1'b1;
        trap_addr = 32'h100;
        @(negedge clk);
        trap = 1'b0;
        #1;
        total++;
        if (fault !== 1'b0) begin
            bad++; $display("FAIL align_clear got=%b exp=0", fault);
        end
        first_valid(seen, pc);
        total++;
        if (seen != 2 || pc !== 32'h100) begin
            bad++;
            $display("FAIL align_recover got=%0d/%h exp=2/100", seen, pc);
        end
`else
        total++;
        if (fault !== 1'b0) begin
            bad++; $display("FAIL align_fault got=%b exp=0", fault);
        end
        first_valid(seen, pc);
        total++;
        if (seen != 2 || pc !== 32'h40) begin
            bad++;
            $display("FAIL align_force got=%0d/%h exp=2/40", seen, pc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_priority();
        test_flush();
        test_stall();
        test_wrap();
        test_mid_reset();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
